// File: rtl/int_issue_queue_if.sv
// Dispatch / CDB / issue signal bundle for the integer issue queue.
// The queue connects through the slave modport; the dispatch/CDB/arbiter side uses master.
interface int_issue_queue_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 4
) ();
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic              i_flush;
    logic              disp_valid;
    logic              disp_ready;
    logic [OP_W-1:0]   disp_op;
    logic [TAG_W-1:0]  disp_rd_tag;
    logic              disp_rs1_vld;
    logic [TAG_W-1:0]  disp_rs1_tag;
    logic [DATA_W-1:0] disp_rs1_data;
    logic              disp_rs2_vld;
    logic [TAG_W-1:0]  disp_rs2_tag;
    logic [DATA_W-1:0] disp_rs2_data;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              issue_rdy;
    logic              issue_granted;
    logic [OP_W-1:0]   issue_op;
    logic [TAG_W-1:0]  issue_rd_tag;
    logic [DATA_W-1:0] issue_rs1_data;
    logic [DATA_W-1:0] issue_rs2_data;
    logic [OCC_W-1:0]  occupancy;

    modport slave (
        input  i_flush, disp_valid, disp_op, disp_rd_tag,
               disp_rs1_vld, disp_rs1_tag, disp_rs1_data,
               disp_rs2_vld, disp_rs2_tag, disp_rs2_data,
               cdb_valid, cdb_tag, cdb_data, issue_granted,
        output disp_ready, issue_rdy, issue_op, issue_rd_tag,
               issue_rs1_data, issue_rs2_data, occupancy
    );

    modport master (
        output i_flush, disp_valid, disp_op, disp_rd_tag,
               disp_rs1_vld, disp_rs1_tag, disp_rs1_data,
               disp_rs2_vld, disp_rs2_tag, disp_rs2_data,
               cdb_valid, cdb_tag, cdb_data, issue_granted,
        input  disp_ready, issue_rdy, issue_op, issue_rd_tag,
               issue_rs1_data, issue_rs2_data, occupancy
    );
endinterface

// File: rtl/int_issue_queue.sv
// Age-ordered shifting integer issue queue with CDB wakeup and oldest-ready issue selection.
// Define WAKEUP_ISSUE_BYPASS_EN to let a live CDB match make an entry issuable in the same cycle.
module int_issue_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 4
) (
    input logic            i_clk,
    input logic            i_rst,
    int_issue_queue_if.slave bus
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

`ifdef WAKEUP_ISSUE_BYPASS_EN
    localparam bit WAKE_BYP = 1'b1;
`else
    localparam bit WAKE_BYP = 1'b0;
`endif

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  rd_tag;
        logic              rs1_vld;
        logic [TAG_W-1:0]  rs1_tag;
        logic [DATA_W-1:0] rs1_data;
        logic              rs2_vld;
        logic [TAG_W-1:0]  rs2_tag;
        logic [DATA_W-1:0] rs2_data;
    } entry_t;

    entry_t           ent_q  [DEPTH];
    entry_t           ent_d  [DEPTH];
    entry_t           ent_w  [DEPTH];
    entry_t           ent_up [DEPTH];
    entry_t           new_ent;
    logic [OCC_W-1:0] occ_q, occ_d, widx;
    logic [DEPTH-1:0] valid, wake1, wake2, ready;
    logic [IDX_W-1:0] sel;
    logic             any_rdy, do_issue, do_disp, disp_ready;

    // Wakeup and readiness per entry; valid entries are exactly indices below occ_q.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            valid[i] = OCC_W'(i) < occ_q;
            wake1[i] = valid[i] & bus.cdb_valid & ~ent_q[i].rs1_vld
                       & (ent_q[i].rs1_tag == bus.cdb_tag);
            wake2[i] = valid[i] & bus.cdb_valid & ~ent_q[i].rs2_vld
                       & (ent_q[i].rs2_tag == bus.cdb_tag);
            ready[i] = valid[i] & (ent_q[i].rs1_vld | (WAKE_BYP & wake1[i]))
                                & (ent_q[i].rs2_vld | (WAKE_BYP & wake2[i]));
            ent_w[i] = ent_q[i];
            if (wake1[i]) begin
                ent_w[i].rs1_vld  = 1'b1;
                ent_w[i].rs1_data = bus.cdb_data;
            end
            if (wake2[i]) begin
                ent_w[i].rs2_vld  = 1'b1;
                ent_w[i].rs2_data = bus.cdb_data;
            end
        end
    end

    // Oldest ready entry wins: scan from the top so the lowest index is assigned last.
    always_comb begin
        sel     = '0;
        any_rdy = 1'b0;
        for (int unsigned i = DEPTH; i > 0; i--) begin
            if (ready[i-1]) begin
                sel     = IDX_W'(i - 1);
                any_rdy = 1'b1;
            end
        end
    end

    always_comb begin
        bus.issue_rdy      = any_rdy;
        bus.issue_op       = '0;
        bus.issue_rd_tag   = '0;
        bus.issue_rs1_data = '0;
        bus.issue_rs2_data = '0;
        if (any_rdy) begin
            bus.issue_op       = ent_q[sel].op;
            bus.issue_rd_tag   = ent_q[sel].rd_tag;
            bus.issue_rs1_data = (WAKE_BYP && wake1[sel]) ? bus.cdb_data : ent_q[sel].rs1_data;
            bus.issue_rs2_data = (WAKE_BYP && wake2[sel]) ? bus.cdb_data : ent_q[sel].rs2_data;
        end
    end

    assign disp_ready     = occ_q < OCC_W'(DEPTH);
    assign bus.disp_ready = disp_ready;
    assign bus.occupancy  = occ_q;

    // Incoming op with same-cycle CDB bypass on its unresolved operands.
    always_comb begin
        new_ent          = '0;
        new_ent.op       = bus.disp_op;
        new_ent.rd_tag   = bus.disp_rd_tag;
        new_ent.rs1_tag  = bus.disp_rs1_tag;
        new_ent.rs2_tag  = bus.disp_rs2_tag;
        new_ent.rs1_vld  = bus.disp_rs1_vld
                           | (bus.cdb_valid & (bus.disp_rs1_tag == bus.cdb_tag));
        new_ent.rs2_vld  = bus.disp_rs2_vld
                           | (bus.cdb_valid & (bus.disp_rs2_tag == bus.cdb_tag));
        new_ent.rs1_data = bus.disp_rs1_vld ? bus.disp_rs1_data : bus.cdb_data;
        new_ent.rs2_data = bus.disp_rs2_vld ? bus.disp_rs2_data : bus.cdb_data;
    end

    // Issue compacts the queue first; dispatch then lands at the new tail.
    always_comb begin
        do_issue = any_rdy & bus.issue_granted & ~bus.i_flush;
        do_disp  = bus.disp_valid & disp_ready & ~bus.i_flush;
        widx     = occ_q - OCC_W'(do_issue);
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
            ent_up[i] = ent_w[i+1];
        end
        ent_up[DEPTH-1] = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_d[i] = (do_issue && (IDX_W'(i) >= sel)) ? ent_up[i] : ent_w[i];
            if (do_disp && (OCC_W'(i) == widx)) begin
                ent_d[i] = new_ent;
            end
        end
        if (bus.i_flush) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + OCC_W'(do_disp) - OCC_W'(do_issue);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            occ_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            occ_q <= occ_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end
endmodule
